// File: rtl/branch_unit.sv
// Program counter and control-flow unit for the 8-bit CPU: increment, relative
// branch, absolute jump, hardware call/return stack and byte-wise PC readback.
module branch_unit #(
  parameter int          STACK_DEPTH = 4,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  localparam int         SPW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cs_in,
  input  logic           cs_out,
  input  logic           byte_sel,
  input  logic [2:0]     cmd,
  input  logic           check_branch,
  input  logic [7:0]     data_in,
  output logic [7:0]     bus_out,
  output logic [15:0]    pc,
  output logic [SPW-1:0] sp,
  output logic           stack_err
);

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_INC     = 3'd1;
  localparam logic [2:0] CMD_BRANCH  = 3'd2;
  localparam logic [2:0] CMD_LOAD_LO = 3'd3;
  localparam logic [2:0] CMD_JUMP    = 3'd4;
  localparam logic [2:0] CMD_CALL    = 3'd5;
  localparam logic [2:0] CMD_RET     = 3'd6;
  localparam logic [2:0] CMD_CLR_ERR = 3'd7;

  localparam logic [SPW-1:0] DEPTH_V = SPW'(STACK_DEPTH);

  logic [7:0]  addr_lo;
  logic [15:0] stack [STACK_DEPTH];
  logic [15:0] pc_inc;
  logic [15:0] br_tgt;
  logic [15:0] jmp_tgt;
  logic [15:0] stack_top;
  logic        stack_full;
  logic        stack_empty;

  // Branch offset is relative to the already-incremented PC.
  assign pc_inc      = pc + 16'd1;
  assign br_tgt      = pc_inc + {{8{data_in[7]}}, data_in};
  assign jmp_tgt     = {data_in, addr_lo};
  assign stack_full  = !(sp < DEPTH_V);
  assign stack_empty = (sp == '0);

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp == SPW'(i + 1)) stack_top = stack[i];
    end
  end

  assign bus_out = cs_out ? (byte_sel ? pc[15:8] : pc[7:0]) : 8'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      addr_lo   <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (cs_in) begin
      case (cmd)
        CMD_NOP:     ;
        CMD_INC:     pc <= pc_inc;
        CMD_BRANCH:  pc <= check_branch ? br_tgt : pc_inc;
        CMD_LOAD_LO: addr_lo <= data_in;
        CMD_JUMP:    pc <= jmp_tgt;
        CMD_CALL: begin
          if (!stack_full) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (sp == SPW'(i)) stack[i] <= pc_inc;
            end
            sp <= sp + 1'b1;
            pc <= jmp_tgt;
          end else begin
            stack_err <= 1'b1;
            pc        <= pc_inc;
          end
        end
        CMD_RET: begin
          if (!stack_empty) begin
            pc <= stack_top;
            sp <= sp - 1'b1;
          end else begin
            stack_err <= 1'b1;
            pc        <= pc_inc;
          end
        end
        CMD_CLR_ERR: stack_err <= 1'b0;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed scenarios then random commands,
// checked against a queue-based reference model of the PC and return stack.
module tb_branch_unit;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RST_PC = 16'h0100;
  localparam int          SPW = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cs_in, cs_out, byte_sel, check_branch;
  logic [2:0]     cmd;
  logic [7:0]     data_in;
  logic [7:0]     bus_out;
  logic [15:0]    pc;
  logic [SPW-1:0] sp;
  logic           stack_err;

  branch_unit #(.STACK_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .cs_in(cs_in), .cs_out(cs_out), .byte_sel(byte_sel),
    .cmd(cmd), .check_branch(check_branch), .data_in(data_in), .bus_out(bus_out),
    .pc(pc), .sp(sp), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]    pc;
    logic [SPW-1:0] sp;
    logic           err;
    logic [7:0]     bus;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;

  logic [15:0] m_pc;
  logic [7:0]  m_lo;
  logic        m_err;
  logic [15:0] m_stk[$];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [7:0] bus_of(input logic co, input logic bs, input logic [15:0] p);
    if (!co) return 8'hzz;
    return bs ? p[15:8] : p[7:0];
  endfunction

  function automatic void model_reset();
    m_pc  = RST_PC;
    m_lo  = 8'h00;
    m_err = 1'b0;
    m_stk.delete();
  endfunction

  function automatic void model_step(input logic [2:0] c, input logic [7:0] d, input logic cb);
    int t;
    case (c)
      3'd1: m_pc = m_pc + 16'd1;
      3'd2: begin
        t = int'(m_pc) + 1 + (cb ? int'($signed(d)) : 0);
        m_pc = 16'(t);
      end
      3'd3: m_lo = d;
      3'd4: m_pc = {d, m_lo};
      3'd5: begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back(m_pc + 16'd1);
          m_pc = {d, m_lo};
        end else begin
          m_err = 1'b1;
          m_pc  = m_pc + 16'd1;
        end
      end
      3'd6: begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_err = 1'b1;
          m_pc  = m_pc + 16'd1;
        end
      end
      3'd7: m_err = 1'b0;
      default: ;
    endcase
  endfunction

  // Drive one cycle; the bus must show the pre-edge PC, then the expected
  // post-edge state goes to the scoreboard for the monitor.
  task automatic issue(input logic cs, input logic [2:0] c, input logic [7:0] d,
                       input logic cb, input logic co, input logic bs);
    exp_t e;
    @(negedge clk);
    cs_in = cs; cmd = c; data_in = d; check_branch = cb; cs_out = co; byte_sel = bs;
    #1;
    chk("bus_pre_edge", {8'h00, bus_out}, {8'h00, bus_of(co, bs, m_pc)});
    if (cs) model_step(c, d, cb);
    e.pc  = m_pc;
    e.sp  = SPW'(m_stk.size());
    e.err = m_err;
    e.bus = bus_of(co, bs, m_pc);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    cs_in = 1'b0;
  endtask

  task automatic cmd1(input logic [2:0] c, input logic [7:0] d);
    issue(1'b1, c, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goto(input logic [15:0] a);
    cmd1(3'd3, a[7:0]);
    cmd1(3'd4, a[15:8]);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_sp"}, 16'(sp), 16'd0);
    chk({tag, "_err"}, 16'(stack_err), 16'd0);
    chk({tag, "_bus"}, {8'h00, bus_out}, {8'h00, bus_of(cs_out, byte_sel, RST_PC)});
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("sp", 16'(sp), 16'(e.sp));
      chk("stack_err", 16'(stack_err), 16'(e.err));
      chk("bus_post_edge", {8'h00, bus_out}, {8'h00, e.bus});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs_in = 1'b0; cs_out = 1'b0; byte_sel = 1'b0;
    check_branch = 1'b0; cmd = 3'd0; data_in = 8'h00;
    model_reset();
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Increment and bus readback
    repeat (3) cmd1(3'd1, 8'h00);
    issue(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("bus_hi_0103", {8'h00, bus_out}, 16'h0001);
    issue(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Relative branches, including wrap through FFFF
    goto(16'h0010);
    issue(1'b1, 3'd2, 8'hF0, 1'b1, 1'b0, 1'b0);
    chk("branch_taken_neg", pc, 16'h0001);
    goto(16'h0010);
    issue(1'b1, 3'd2, 8'hF0, 1'b0, 1'b0, 1'b0);
    chk("branch_not_taken", pc, 16'h0011);
    goto(16'hFFFE);
    issue(1'b1, 3'd2, 8'h05, 1'b1, 1'b1, 1'b0);
    chk("branch_wrap", pc, 16'h0004);

    // addr_lo survives NOP and idle cycles
    cmd1(3'd3, 8'h34);
    cmd1(3'd0, 8'hEE);
    issue(1'b0, 3'd4, 8'h99, 1'b0, 1'b0, 1'b0);
    cmd1(3'd4, 8'h12);
    chk("jump_1234", pc, 16'h1234);

    // Nested calls, overflow, unwinding
    goto(16'h0200);
    for (int i = 1; i <= 4; i++) begin
      cmd1(3'd3, 8'h00);
      cmd1(3'd5, 8'(i * 16));
    end
    chk("sp_full", 16'(sp), 16'd4);
    cmd1(3'd5, 8'h50);
    chk("overflow_pc", pc, 16'h4001);
    chk("overflow_err", 16'(stack_err), 16'd1);
    cmd1(3'd7, 8'h00);
    cmd1(3'd6, 8'h00);
    chk("ret_3001", pc, 16'h3001);
    repeat (3) cmd1(3'd6, 8'h00);
    chk("ret_0201", pc, 16'h0201);

    // Underflow, sticky error, clear
    cmd1(3'd6, 8'h00);
    chk("underflow_pc", pc, 16'h0202);
    cmd1(3'd1, 8'h00);
    chk("err_sticky", 16'(stack_err), 16'd1);
    cmd1(3'd7, 8'h00);
    chk("err_cleared", 16'(stack_err), 16'd0);

    // Asynchronous reset mid-cycle discards stack and addr_lo
    cmd1(3'd3, 8'h00); cmd1(3'd5, 8'h60); cmd1(3'd5, 8'h70);
    goto(16'h5555);
    cmd1(3'd3, 8'h77);
    cs_out = 1'b1; byte_sel = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cmd1(3'd4, 8'hAB);
    chk("jump_after_reset", pc, 16'hAB00);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) chk("scoreboard_drain", 16'(exp_q.size()), 16'd0);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
